// File: rtl/cmp_pkg.sv
// Shared types for the sequential cascade comparator: the lt/eq/gt cascade
// triple, its canonical values, the control FSM states, and a sizing helper.
package cmp_pkg;

   // Cascade triple as carried between nibble stages.
   typedef struct packed {
      logic l;
      logic e;
      logic g;
   } cascade_t;

   localparam cascade_t CASC_EQ = '{l: 1'b0, e: 1'b1, g: 1'b0};
   localparam cascade_t CASC_LT = '{l: 1'b1, e: 1'b0, g: 1'b0};
   localparam cascade_t CASC_GT = '{l: 1'b0, e: 1'b0, g: 1'b1};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Nibble index width; a single-nibble build still needs one bit.
   function automatic int idx_width(input int nibbles);
      return (nibbles > 1) ? $clog2(nibbles) : 1;
   endfunction

endpackage

// File: rtl/nibble_cascade_cmp.sv
// One 4-bit cascaded magnitude compare stage. Any difference in this nibble
// overrides the lower-order cascade; equal nibbles pass the cascade through
// untouched (including illegal 000/111 codes, like a hardware chain).
module nibble_cascade_cmp
   import cmp_pkg::*;
(
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  cascade_t   casc_i,
   output cascade_t   casc_o
);

   // Higher-order difference wins, otherwise forward the incoming cascade.
   always_comb begin
      casc_o = casc_i;
      if (a_i > b_i)
         casc_o = CASC_GT;
      else if (a_i < b_i)
         casc_o = CASC_LT;
   end

endmodule

// File: rtl/seq_cascade_comparator.sv
// Multi-cycle unsigned magnitude comparator. A single nibble stage is reused
// LSB-first; its result is registered and fed back as the cascade input for
// the next nibble, matching a ripple chain of 4-bit cascade comparators.
module seq_cascade_comparator
   import cmp_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             lin,
   input  logic             ein,
   input  logic             gin,
   output logic             busy,
   output logic             done,
   output logic             lt,
   output logic             eq,
   output logic             gt
);

   localparam int NIBBLES = WIDTH / 4;
   localparam int IDX_W   = idx_width(NIBBLES);

   generate
      if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
         $error("seq_cascade_comparator: WIDTH must be a multiple of 4 and >= 4");
      end
   endgenerate

   state_t                   state_q, state_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [WIDTH-1:0]         a_q, a_d, b_q, b_d;
   cascade_t                 casc_q, casc_d;
   cascade_t                 res_q, res_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;

   logic [NIBBLES-1:0][3:0]  a_nib, b_nib;
   cascade_t                 casc_nxt;
   logic                     last_nib;
   logic                     accept;

   assign a_nib    = a_q;
   assign b_nib    = b_q;
   assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

   nibble_cascade_cmp u_nib (
      .a_i    (a_nib[idx_q]),
      .b_i    (b_nib[idx_q]),
      .casc_i (casc_q),
      .casc_o (casc_nxt)
   );

   // Control FSM and datapath next-state; start is honoured only in IDLE/DONE.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      casc_d  = casc_q;
      res_d   = res_q;
      busy_d  = busy_q;
      done_d  = done_q;
      accept  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) accept = 1'b1;
         end
         RUN: begin
            casc_d = casc_nxt;
            idx_d  = idx_q + 1'b1;
            if (last_nib) begin
               res_d   = casc_nxt;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               idx_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            done_d  = 1'b0;
            state_d = IDLE;
            if (start) accept = 1'b1;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase

      // Accepting a start (from IDLE or back-to-back from DONE) loads operands.
      if (accept) begin
         a_d     = a;
         b_d     = b;
         casc_d  = '{l: lin, e: ein, g: gin};
         idx_d   = '0;
         busy_d  = 1'b1;
         done_d  = 1'b0;
         state_d = RUN;
      end
   end

   // State registers; reset aborts any compare in flight and clears results.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         casc_q  <= '0;
         res_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         casc_q  <= casc_d;
         res_q   <= res_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign lt   = res_q.l;
   assign eq   = res_q.e;
   assign gt   = res_q.g;

endmodule

// File: tb/tb_seq_cascade_comparator.sv
// Directed bench for seq_cascade_comparator (WIDTH=16): a vector table of
// operand/cascade/expected-result records plus hand-written sequences for
// back-to-back operation and mid-compare reset.
module tb_seq_cascade_comparator;

   logic        clk = 1'b0;
   logic        rst, start, lin, ein, gin;
   logic [15:0] a, b;
   logic        busy, done, lt, eq, gt;

   int tests = 0;
   int fails = 0;

   seq_cascade_comparator #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .lin   (lin),
      .ein   (ein),
      .gin   (gin),
      .busy  (busy),
      .done  (done),
      .lt    (lt),
      .eq    (eq),
      .gt    (gt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [2:0]  casc;   // {lin, ein, gin}
      logic [2:0]  exp;    // {lt, eq, gt}
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One edge, then settle; inputs are driven and outputs sampled here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue a single start and wait (bounded) for done. Returns the cycle of
   // done (-1 on timeout), the number of busy cycles before it, and whether
   // the held result changed before done.
   task automatic do_cmp(input logic [15:0] av, input logic [15:0] bv,
                         input logic [2:0] cv, output int lat,
                         output int nbusy, output bit changed);
      logic [2:0] prev;
      prev    = {lt, eq, gt};
      lat     = -1;
      nbusy   = 0;
      changed = 1'b0;
      a = av; b = bv; {lin, ein, gin} = cv; start = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         start = 1'b0;
         a = 16'hxxxx; b = 16'hxxxx;
         if (done) begin
            lat = k;
            break;
         end
         if (busy) nbusy++;
         if ({lt, eq, gt} !== prev) changed = 1'b1;
      end
   endtask

   initial begin
      int  lat, nbusy;
      bit  changed;
      int  done_at[$];
      logic [2:0] res_at[$];

      vecs[0] = '{a: 16'h1234, b: 16'h1234, casc: 3'b010, exp: 3'b010};
      vecs[1] = '{a: 16'h8000, b: 16'h7FFF, casc: 3'b010, exp: 3'b001};
      vecs[2] = '{a: 16'h00A0, b: 16'h00B0, casc: 3'b001, exp: 3'b100};
      vecs[3] = '{a: 16'hFFFF, b: 16'hFFFF, casc: 3'b100, exp: 3'b100};
      vecs[4] = '{a: 16'h0F0F, b: 16'h0F0F, casc: 3'b111, exp: 3'b111};
      vecs[5] = '{a: 16'h0001, b: 16'h0000, casc: 3'b100, exp: 3'b001};
      vecs[6] = '{a: 16'h0000, b: 16'h0000, casc: 3'b000, exp: 3'b000};
      vecs[7] = '{a: 16'hFFFE, b: 16'hFFFF, casc: 3'b001, exp: 3'b100};
      vecs[8] = '{a: 16'h1000, b: 16'h0FFF, casc: 3'b100, exp: 3'b001};
      vecs[9] = '{a: 16'h5A5A, b: 16'h5A5A, casc: 3'b001, exp: 3'b001};

      rst = 1'b1; start = 1'b0; a = '0; b = '0; lin = 1'b0; ein = 1'b0; gin = 1'b0;
      tick();
      tick();
      check("reset_outputs", {busy, done, lt, eq, gt}, 5'b00000);
      rst = 1'b0;
      tick();
      check("idle_outputs", {busy, done, lt, eq, gt}, 5'b00000);

      // Table-driven single compares.
      for (int i = 0; i < 10; i++) begin
         do_cmp(vecs[i].a, vecs[i].b, vecs[i].casc, lat, nbusy, changed);
         check($sformatf("vec%0d_latency", i), lat, 5);
         check($sformatf("vec%0d_busy_cycles", i), nbusy, 4);
         check($sformatf("vec%0d_result", i), {lt, eq, gt}, vecs[i].exp);
         check($sformatf("vec%0d_busy_at_done", i), busy, 1'b0);
         check($sformatf("vec%0d_held", i), changed, 1'b0);
         tick();
         check($sformatf("vec%0d_done_pulse", i), done, 1'b0);
         check($sformatf("vec%0d_result_held_idle", i), {lt, eq, gt}, vecs[i].exp);
      end

      // Back-to-back: start held high. The operand change while busy must be
      // ignored until the done cycle, where it starts the second compare.
      a = 16'd5; b = 16'd3; {lin, ein, gin} = 3'b010; start = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k == 1) begin a = 16'd3; b = 16'd5; end
         if (done) begin
            done_at.push_back(k);
            res_at.push_back({lt, eq, gt});
         end
         if (k == 10) start = 1'b0;
      end
      check("b2b_done_count", done_at.size(), 2);
      if (done_at.size() == 2) begin
         check("b2b_first_done", done_at[0], 5);
         check("b2b_second_done", done_at[1], 10);
         check("b2b_first_result", res_at[0], 3'b001);
         check("b2b_second_result", res_at[1], 3'b100);
      end

      // Reset at cycle 3 of a compare: abort, outputs cleared, no done pulse.
      a = 16'd9; b = 16'd2; {lin, ein, gin} = 3'b010; start = 1'b1;
      tick();
      start = 1'b0;
      check("rstrun_busy_c1", busy, 1'b1);
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("rstrun_outputs", {busy, done, lt, eq, gt}, 5'b00000);
      rst = 1'b0;
      begin
         int seen;
         seen = 0;
         for (int k = 0; k < 8; k++) begin
            tick();
            if (done || busy) seen++;
         end
         check("rstrun_no_done", seen, 0);
      end
      do_cmp(16'h0002, 16'h0009, 3'b010, lat, nbusy, changed);
      check("after_rst_latency", lat, 5);
      check("after_rst_result", {lt, eq, gt}, 3'b100);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
